uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue feeding the UART transmitter. Buffers host bytes in a sync FIFO.
//  Drains one byte at a time: pulses the transmitter's write strobe, then waits
//  out its busy window. Sits directly upstream of the transmitter data/Tx_WR inputs.
// PARAMETERS
//  ADDR_W     4   FIFO address width; depth = 2**ADDR_W entries (16)
//  BUSY_WAIT  15  max cycles to wait for tx_busy to rise after a strobe (1..255)
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  reset       in   1         synchronous, active-high reset
//  wr_en       in   1         host push strobe, one byte per cycle
//  wr_data     in   8         host byte
//  full        out  1         FIFO holds 2**ADDR_W bytes
//  empty       out  1         FIFO holds 0 bytes
//  level       out  ADDR_W+1  current occupancy 0..2**ADDR_W
//  overflow    out  1         sticky: a push was dropped while full
//  tx_enable   in   1         permits starting a new byte; no effect on one in flight
//  tx_busy     in   1         transmitter busy
//  tx_wr       out  1         one-cycle write strobe to transmitter
//  tx_data     out  8         byte presented to transmitter
// BEHAVIOUR
//  Reset: level=0, empty=1, full=0, overflow=0, tx_wr=0, tx_data=8'h00, state IDLE.
//  FIFO: circular, rd/wr pointers ADDR_W+1 bits; MSB differs and rest equal = full.
//   Pointer wrap from 2**ADDR_W-1 to 0 is silent. full/empty/level are registered state.
//  Push: accepted iff wr_en && !full at the sampling edge. When full, the byte is
//   dropped and overflow is set; it clears only on reset. A pop in the same cycle
//   does not rescue a push made while full.
//  Push+pop same cycle (not full): level unchanged, both pointers advance.
//  FSM (state register; tx_wr = (state==LOAD)):
//   IDLE    : if !empty && tx_enable && !tx_busy -> pop head into tx_data, go to LOAD
//   LOAD    : tx_wr=1 for exactly this cycle -> WAIT_HI, clear wait counter
//   WAIT_HI : tx_busy=1 -> WAIT_LO; else counter increments; at BUSY_WAIT -> IDLE
//             (byte counted as sent; no retry)
//   WAIT_LO : tx_busy=0 -> IDLE
//  Latency: push into empty queue at edge N -> tx_wr high in cycle N+2.
//  Back-to-back bytes: IDLE is re-entered on the cycle after busy falls. Next tx_wr
//   occurs 2 cycles after tx_busy falls.
//  tx_data holds from the pop until the next pop; it is never changed while in LOAD,
//   WAIT_HI or WAIT_LO.
//  tx_enable low: FSM holds in IDLE. A byte already past IDLE completes normally.
//  Reset mid-transfer: FIFO contents are discarded, and tx_wr is 0 from the next cycle.
// CONFIGURATION
//  UART_TXQ_DROP_CNT_EN defined: extra output drop_count out 8. It counts rejected
//   pushes, saturates at 8'hFF and resets to 0. overflow = (drop_count != 0).
//  Not defined: there is no drop_count port, and overflow is a 1-bit sticky flop.
// STRUCTURE
//  uart_pkg: DATA_W=8; state enum IDLE/LOAD/WAIT_HI/WAIT_LO (2-bit encoding).
//  Sub-module uart_sync_fifo (storage, pointers, full/empty/level).
//  The FSM, wait counter and tx_data register live in uart_tx_queue.
// TESTING
//  1. Push 8'hA5 into an empty queue, tx_enable=1, busy model rises 1 cycle after
//     tx_wr and holds 20 cycles -> one tx_wr pulse at N+2 with tx_data=A5.
//     No second pulse; empty=1 after the pop.
//  2. Push 16 bytes 00..0F, then push 8'hFF -> full=1, level=16, overflow=1.
//     The bytes drain in order 00..0F and FF is never sent.
//  3. tx_enable=0, push 3 bytes -> no tx_wr, level=3. Raise tx_enable -> 3 strobes,
//     each after busy falls, with tx_wr spacing = busy length + 3 cycles.
//  4. Busy model never rises -> after tx_wr, FSM returns to IDLE after 15 cycles.
//     The next byte then strobes.
//  5. Assert reset during WAIT_LO with 5 bytes queued -> next cycle level=0,
//     empty=1, tx_wr=0. There are no strobes after reset releases.
//  6. With UART_TXQ_DROP_CNT_EN defined: 300 pushes while full -> drop_count
//     saturates at FF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit queue.
// Optional drop counter in the top is enabled by UART_TXQ_DROP_CNT_EN.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    // Saturating 8-bit increment, sticks at 8'hFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO with extra-MSB pointers; full/empty/level are
// registered and derived from the next-state pointers.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DW     = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    output logic [DW-1:0]     rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_level;
    logic            r_full;
    logic            r_empty;

    logic            w_push;
    logic            w_pop;
    logic [ADDR_W:0] w_wr_ptr_next;
    logic [ADDR_W:0] w_rd_ptr_next;

    // A push while full is refused even if a pop frees a slot this cycle.
    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !r_empty;

    assign w_wr_ptr_next = r_wr_ptr + (ADDR_W + 1)'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + (ADDR_W + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_wr_ptr_next - w_rd_ptr_next;
            r_full   <= (w_wr_ptr_next[ADDR_W] != w_rd_ptr_next[ADDR_W]) &&
                        (w_wr_ptr_next[ADDR_W-1:0] == w_rd_ptr_next[ADDR_W-1:0]);
            r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Head is read combinationally; the consumer registers it on pop.
    assign rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign full    = r_full;
    assign empty   = r_empty;
    assign level   = r_level;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART transmitter: pops one byte, strobes tx_wr,
// waits out tx_busy. Define UART_TXQ_DROP_CNT_EN to add the drop_count output.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int BUSY_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
`ifdef UART_TXQ_DROP_CNT_EN
    output logic [7:0]        drop_count,
`endif
    input  logic              tx_enable,
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [DATA_W-1:0] tx_data
);

    localparam logic [7:0] WAIT_LAST = 8'(BUSY_WAIT - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_cnt_next;
    logic [DATA_W-1:0] r_tx_data;

    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W:0]   w_level;
    logic [DATA_W-1:0] w_rd_data;

    uart_sync_fifo #(
        .ADDR_W (ADDR_W),
        .DW     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign w_drop = wr_en && w_full;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && tx_enable && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next    = WAIT_HI;
                w_wait_cnt_next = '0;
            end
            WAIT_HI: begin
                // A transmitter that never acknowledges is given up on; the byte is not retried.
                if (tx_busy) begin
                    w_state_next = WAIT_LO;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_pop) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_drop_count <= sat_inc8(r_drop_count);
        end
    end

    assign drop_count = r_drop_count;
    assign overflow   = (r_drop_count != 8'd0);
`else
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    assign full    = w_full;
    assign empty   = w_empty;
    assign level   = w_level;
    assign tx_wr   = (r_state == LOAD);
    assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: queue/timing reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_queue;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int BW    = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        overflow;
    logic        tx_enable;
    logic        tx_busy;
    logic        tx_wr;
    logic [7:0]  tx_data;
`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    uart_tx_queue #(.ADDR_W(AW), .BUSY_WAIT(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
`ifdef UART_TXQ_DROP_CNT_EN
        .drop_count (drop_count),
`endif
        .tx_enable  (tx_enable),
        .tx_busy    (tx_busy),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data)
    );

    initial forever #5 clk = ~clk;

    // cyc == k during the interval after rising edge k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         edge_no;
        logic [7:0] data;
    } strobe_t;
    strobe_t log_q[$];

    // ---------------- transmitter busy model ----------------
    int bm_delay = 1;
    int bm_len   = 5;
    bit bm_never = 1'b0;
    bit bm_rand  = 1'b0;

    initial begin
        int rise_c;
        int fall_c;
        int d;
        int l;
        rise_c  = -1;
        fall_c  = -1;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_wr === 1'b1) begin
                if (bm_rand) begin
                    d = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 3) : $urandom_range(4, BW + 3);
                    l = $urandom_range(1, 6);
                    if ($urandom_range(0, 9) != 0) begin
                        rise_c = cyc + d;
                        fall_c = rise_c + l;
                    end
                end else if (!bm_never) begin
                    rise_c = cyc + bm_delay;
                    fall_c = rise_c + bm_len;
                end
            end
            tx_busy = (cyc >= rise_c) && (cyc < fall_c);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin
        logic [7:0] mq[$];
        bit         m_valid;
        bit         e_wr;
        logic [7:0] e_data;
        bit         e_ovf;
        int         e_drop;
        bit         in_xfer;
        int         idle_from;
        int         strobe_at;
        int         rise_at;
        bit         pop;
        bit         full_pre;
        int         c;
        m_valid   = 1'b0;
        e_wr      = 1'b0;
        e_data    = 8'h00;
        e_ovf     = 1'b0;
        e_drop    = 0;
        in_xfer   = 1'b0;
        idle_from = 0;
        strobe_at = 0;
        rise_at   = -1;
        forever begin
            @(negedge clk);
            c = cyc;
            if (m_valid) begin
                check("level",    32'(level),    mq.size());
                check("empty",    32'(empty),    32'(mq.size() == 0));
                check("full",     32'(full),     32'(mq.size() == DEPTH));
                check("overflow", 32'(overflow), 32'(e_ovf));
                check("tx_wr",    32'(tx_wr),    32'(e_wr));
                check("tx_data",  32'(tx_data),  32'(e_data));
`ifdef UART_TXQ_DROP_CNT_EN
                check("drop_count", 32'(drop_count), e_drop);
`endif
                if (tx_wr === 1'b1) begin
                    log_q.push_back('{c + 1, tx_data});
                    if (verbose) $display("[TB] strobe sampled at edge %0d data %02h", c + 1, tx_data);
                end
            end
            // next state after the coming edge
            if (reset === 1'b1) begin
                mq.delete();
                e_ovf     = 1'b0;
                e_drop    = 0;
                e_wr      = 1'b0;
                e_data    = 8'h00;
                in_xfer   = 1'b0;
                idle_from = c + 1;
                m_valid   = 1'b1;
            end else if (m_valid) begin
                // a transfer ends on the busy-fall or after BW silent cycles
                if (in_xfer && c > strobe_at) begin
                    if (rise_at < 0) begin
                        if (tx_busy) rise_at = c;
                        else if (c == strobe_at + BW) begin
                            in_xfer   = 1'b0;
                            idle_from = c + 1;
                        end
                    end else if (c > rise_at && !tx_busy) begin
                        in_xfer   = 1'b0;
                        idle_from = c + 1;
                    end
                end
                pop      = !in_xfer && (c >= idle_from) && (mq.size() > 0) && tx_enable && !tx_busy;
                full_pre = (mq.size() == DEPTH);
                e_wr     = pop;
                if (pop) begin
                    e_data    = mq.pop_front();
                    in_xfer   = 1'b1;
                    strobe_at = c + 1;
                    rise_at   = -1;
                end
                if (wr_en) begin
                    if (full_pre) begin
                        e_ovf = 1'b1;
                        if (e_drop < 255) e_drop++;
                    end else begin
                        mq.push_back(wr_data);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        step_n(2);
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(log_q.size() >= n), 32'd1);
    endtask

    initial begin
        int n_edge;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        tx_enable = 1'b0;
        step_n(3);
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_tx_wr", 32'(tx_wr), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'h00);
        reset = 1'b0;

        // 1: single byte latency
        $display("[TB] test 1: single byte");
        do_reset();
        tx_enable = 1'b1;
        bm_delay  = 1;
        bm_len    = 20;
        push(8'hA5);
        n_edge = cyc;
        step_n(40);
        check("t1_count", log_q.size(), 32'd1);
        if (log_q.size() >= 1) begin
            check("t1_edge", log_q[0].edge_no, n_edge + 2);
            check("t1_data", 32'(log_q[0].data), 32'hA5);
        end
        check("t1_empty", 32'(empty), 32'd1);

        // 2: fill, overflow, in-order drain
        $display("[TB] test 2: fill and overflow");
        do_reset();
        tx_enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hFF);
        check("t2_full", 32'(full), 32'd1);
        check("t2_level", 32'(level), 32'd16);
        check("t2_overflow", 32'(overflow), 32'd1);
        log_q.delete();
        bm_len    = 3;
        tx_enable = 1'b1;
        wait_log("t2_wait", 16, 400);
        step_n(30);
        check("t2_count", log_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < log_q.size()) check("t2_order", 32'(log_q[i].data), i);
        end
        check("t2_empty", 32'(empty), 32'd1);

        // 3: tx_enable gating and back-to-back spacing
        $display("[TB] test 3: enable gating");
        do_reset();
        tx_enable = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step_n(5);
        check("t3_no_strobe", log_q.size(), 32'd0);
        check("t3_level", 32'(level), 32'd3);
        bm_len    = 5;
        tx_enable = 1'b1;
        wait_log("t3_wait", 3, 200);
        if (log_q.size() >= 3) begin
            check("t3_gap1", log_q[1].edge_no - log_q[0].edge_no, 32'd8);
            check("t3_gap2", log_q[2].edge_no - log_q[1].edge_no, 32'd8);
            check("t3_data", 32'(log_q[2].data), 32'h33);
        end
        step_n(20);

        // 4: busy never rises -> timeout
        $display("[TB] test 4: busy timeout");
        do_reset();
        bm_never  = 1'b1;
        tx_enable = 1'b1;
        push(8'h44);
        push(8'h55);
        wait_log("t4_wait", 2, 200);
        if (log_q.size() >= 2) begin
            check("t4_gap", log_q[1].edge_no - log_q[0].edge_no, BW + 2);
            check("t4_data0", 32'(log_q[0].data), 32'h44);
            check("t4_data1", 32'(log_q[1].data), 32'h55);
        end
        step_n(20);
        bm_never = 1'b0;

        // 5: reset while waiting for busy to fall
        $display("[TB] test 5: reset mid-transfer");
        do_reset();
        tx_enable = 1'b1;
        bm_delay  = 1;
        bm_len    = 20;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        check("t5_level_pre", 32'(level), 32'd5);
        check("t5_one_strobe", log_q.size(), 32'd1);
        reset = 1'b1;
        step();
        check("t5_level", 32'(level), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_tx_wr", 32'(tx_wr), 32'd0);
        reset = 1'b0;
        log_q.delete();
        step_n(40);
        check("t5_no_strobe", log_q.size(), 32'd0);

`ifdef UART_TXQ_DROP_CNT_EN
        // 6: saturating drop counter
        $display("[TB] test 6: drop counter");
        do_reset();
        tx_enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        wr_en = 1'b1;
        step_n(300);
        wr_en = 1'b0;
        check("t6_drop", 32'(drop_count), 32'hFF);
        check("t6_overflow", 32'(overflow), 32'd1);
`endif

        // randomized traffic against the model
        $display("[TB] random phase");
        verbose = 1'b0;
        do_reset();
        bm_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_en     = ($urandom_range(0, 99) < ((i < 1500) ? 60 : 20));
            wr_data   = 8'($urandom);
            tx_enable = ($urandom_range(0, 9) != 0);
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end
        wr_en   = 1'b0;
        reset   = 1'b0;
        bm_rand = 1'b0;
        step_n(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
